decode_grf: RTL and testbench

- General register file for the decode (D) stage of the 5-stage MIPS pipeline.
- 32 x 32-bit registers, with $0 hardwired to zero.
- Two combinational read ports (rs, rt) and one synchronous write port driven from the write-back stage.
- Internal write-to-read bypass, so D sees a value written in the same cycle.

---
 rtl/decode_grf.sv | 75 +++++++
 tb/tb_decode_grf.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/decode_grf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decode_grf : 31 stored GPRs plus hardwired $0, two combinational read ports,
// one write port with same-cycle write-to-read bypass. Optional write log:
// GRF_DISPLAY_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module decode_grf #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [5:0]  rs,
  input  logic [5:0]  rt,
  input  logic [4:0]  regDst,
  input  logic [31:0] regWd,
  output logic [31:0] grf_rs,
  output logic [31:0] grf_rt
);

  logic [DATA_W-1:0] regs [1:NREG-1];
  logic [DATA_W-1:0] rd_rs;
  logic [DATA_W-1:0] rd_rt;
  logic [4:0]        addr_rs;
  logic [4:0]        addr_rt;

  assign addr_rs = rs[4:0];
  assign addr_rt = rt[4:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (regDst != 5'd0) begin
      for (int i = 1; i < NREG; i++) begin
        if (regDst == 5'(i)) begin
          regs[i] <= regWd;
        end
      end
    end
  end

  // Address 0 never matches the loop, so $0 falls through to the zero default.
  always_comb begin
    rd_rs = '0;
    rd_rt = '0;
    for (int i = 1; i < NREG; i++) begin
      if (addr_rs == 5'(i)) rd_rs = regs[i];
      if (addr_rt == 5'(i)) rd_rt = regs[i];
    end
  end

  assign grf_rs = !reset ? 32'd0 :
                  ((addr_rs != 5'd0) && (addr_rs == regDst)) ? regWd : rd_rs;
  assign grf_rt = !reset ? 32'd0 :
                  ((addr_rt != 5'd0) && (addr_rt == regDst)) ? regWd : rd_rt;

`ifdef GRF_DISPLAY_EN
  always @(posedge clk) begin
    if (reset && (regDst != 5'd0)) begin
      $display("@%h: $%d <= %h", pc, regDst, regWd);
    end
  end

  logic unused_bits;
  assign unused_bits = ^{rs[5], rt[5]};
`else
  logic unused_bits;
  assign unused_bits = ^{pc, rs[5], rt[5]};
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_grf.sv
`default_nettype none
`timescale 1ns/1ps
// Testbench for decode_grf: directed steps plus random traffic against an
// architectural register-file model.
module tb_decode_grf;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [5:0]  rs;
  logic [5:0]  rt;
  logic [4:0]  regDst;
  logic [31:0] regWd;
  logic [31:0] grf_rs;
  logic [31:0] grf_rt;

  int errors = 0;
  int checks = 0;
  logic [31:0] model [32];

  decode_grf dut (
    .clk    (clk),
    .reset  (reset),
    .pc     (pc),
    .rs     (rs),
    .rt     (rt),
    .regDst (regDst),
    .regWd  (regWd),
    .grf_rs (grf_rs),
    .grf_rt (grf_rt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_read(input logic [5:0] a);
    int r;
    r = int'(a) % 32;
    if (!reset) return 32'd0;
    if (r == 0) return 32'd0;
    if (r == int'(regDst)) return regWd;
    return model[r];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ports(input string tag);
    #1;
    chk({tag, "_rs"}, grf_rs, exp_read(rs));
    chk({tag, "_rt"}, grf_rt, exp_read(rt));
  endtask

  task automatic drive(input logic [5:0] a, input logic [5:0] b,
                       input logic [4:0] d, input logic [31:0] wd);
    rs = a; rt = b; regDst = d; regWd = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset && regDst != 5'd0) model[regDst] = regWd;
    @(negedge clk);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  initial begin
    reset = 1'b0; pc = 32'h0;
    clear_model();
    drive(6'd0, 6'd0, 5'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);

    // Reset held: reads zero, writes blocked
    drive(6'd5, 6'd31, 5'd5, 32'h1234);
    chk_ports("rst_read");
    tick();
    chk("rst_hold_rs", grf_rs, 32'd0);
    reset = 1'b1;
    regDst = 5'd0;
    chk_ports("rst_release");
    chk("rst_no_write", grf_rs, 32'd0);

    // Write and read back
    drive(6'd0, 6'd0, 5'd8, 32'hDEADBEEF);
    tick();
    drive(6'd8, 6'd0, 5'd0, 32'd0);
    #1 chk("wr8", grf_rs, 32'hDEADBEEF);
    drive(6'd0, 6'd0, 5'd9, 32'h0000_0001);
    tick();
    drive(6'd8, 6'd9, 5'd0, 32'd0);
    #1 chk("wr8_kept", grf_rs, 32'hDEADBEEF);
    chk("wr9", grf_rt, 32'h1);

    // $0 immutable
    drive(6'd0, 6'd0, 5'd0, 32'hFFFFFFFF);
    tick();
    chk_ports("zero");
    chk("zero_const", grf_rs, 32'd0);

    // Bypass
    drive(6'd0, 6'd0, 5'd3, 32'h11);
    tick();
    drive(6'd3, 6'd4, 5'd3, 32'h22);
    #1 chk("bypass_pre", grf_rs, 32'h22);
    chk_ports("bypass_pre");
    tick();
    regDst = 5'd0;
    #1 chk("bypass_post", grf_rs, 32'h22);
    chk_ports("bypass_post");

    // Address bit 5 ignored
    drive(6'd0, 6'd0, 5'd7, 32'hA5A5A5A5);
    tick();
    drive(6'b100111, 6'b000111, 5'd0, 32'd0);
    #1 chk("bit5_rs", grf_rs, 32'hA5A5A5A5);
    chk("bit5_rt", grf_rt, 32'hA5A5A5A5);

    // Logged write example
    pc = 32'h3000;
    drive(6'd2, 6'd34, 5'd2, 32'h5);
    chk_ports("log_wr");
    tick();
    pc = 32'h0;

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      drive(6'($urandom), 6'($urandom),
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom);
      pc = $urandom;
      chk_ports("rand");
      tick();
    end

    // Preload index values, then async reset between edges
    for (int i = 1; i < 32; i++) begin
      drive(6'd0, 6'd0, 5'(i), 32'(i));
      tick();
    end
    regDst = 5'd0;
    for (int i = 0; i < 32; i += 2) begin
      drive(6'(i), 6'(i + 1), 5'd0, 32'd0);
      #0.1;
      chk("preload_rs", grf_rs, exp_read(rs));
      chk("preload_rt", grf_rt, 32'(i + 1));
    end
    #0.5;
    reset = 1'b0;
    clear_model();
    for (int i = 0; i < 32; i++) begin
      rs = 6'(i); rt = 6'(31 - i);
      #0.1;
      chk("async_rs", grf_rs, 32'd0);
      chk("async_rt", grf_rt, 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    drive(6'd17, 6'd30, 5'd0, 32'd0);
    chk_ports("post_async");

    // Reset asserted on the same edge as a write: reset wins
    drive(6'd12, 6'd13, 5'd12, 32'hCAFEF00D);
    @(posedge clk);
    reset = 1'b0;
    clear_model();
    @(negedge clk);
    reset = 1'b1;
    drive(6'd12, 6'd13, 5'd0, 32'd0);
    #1 chk("edge_rst", grf_rs, 32'd0);
    chk_ports("edge_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
